// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings and helpers for the fetch/data memory arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int MAX_BE_W = 64;
    localparam logic [MAX_BE_W-1:0] BE_ALL_ONES = '1;

    // A zero TIMEOUT still needs a one-bit counter to keep the port widths legal.
    function automatic int timer_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: saturating response-wait timer; expired_o flags TIMEOUT cycles elapsed.
module mem_timeout_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int TW = timer_width(TIMEOUT);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clear_i ? '0 : (en_i && cnt_q != LIMIT) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data requests onto one single-ported memory,
// alternating on contention and completing stuck accesses through a timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                bus_err
);

    localparam int BE_W = DATA_W / 8;

    state_e            state_q, state_d;
    logic              sel_q, sel_d, last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic              i_pend, d_pend, pick, tmr_clr, expired;
    logic [DATA_W-1:0] resp;

    // A request still high during its own completion pulse is not a new request yet.
    assign i_pend = i_req & ~i_rvalid_q;
    assign d_pend = d_req & ~d_rvalid_q;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmr (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (tmr_clr),
        .en_i      (state_q == ST_WAIT),
        .expired_o (expired)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;
        tmr_clr    = 1'b0;
        resp       = mem_rvalid ? mem_rdata : '0;
        pick       = (i_pend && d_pend) ? ~last_q : d_pend;
        case (state_q)
            ST_IDLE: if (i_pend || d_pend) begin
                state_d = ST_ADDR;
                sel_d   = pick;
                addr_d  = (pick == PORT_D) ? d_addr : i_addr;
                we_d    = (pick == PORT_D) & d_we;
                wdata_d = (pick == PORT_D) ? d_wdata : '0;
                be_d    = (pick == PORT_D) ? d_be : BE_ALL_ONES[BE_W-1:0];
            end
            ST_ADDR: if (mem_gnt) begin
                state_d = ST_WAIT;
                tmr_clr = 1'b1;
                last_d  = sel_q;
            end
            ST_WAIT: if (mem_rvalid || expired) begin
                state_d    = ST_IDLE;
                i_rvalid_d = (sel_q == PORT_I);
                d_rvalid_d = (sel_q == PORT_D);
                i_rdata_d  = (sel_q == PORT_I) ? resp : i_rdata_q;
                d_rdata_d  = (sel_q == PORT_D) ? resp : d_rdata_q;
                err_d      = err_q | ~mem_rvalid;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= PORT_I;
            last_q     <= PORT_I;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    assign mem_req   = (state_q == ST_ADDR);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign bus_err   = err_q;
    // Stalls release during reset so the pipeline never sees a stall without a live transaction.
    assign i_stall   = i_req & ~i_rvalid_q & ~reset;
    assign d_stall   = d_req & ~d_rvalid_q & ~reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a transaction-level reference model and per-cycle compare.
module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic        clk, reset;
    logic        i_req, d_req, d_we, mem_gnt, mem_rvalid;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        i_rvalid, i_stall, d_rvalid, d_stall, mem_req, mem_we, bus_err;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction record plus expected response registers.
    logic        t_act, t_gr, t_port, t_we, last_g;
    logic [31:0] t_addr, t_wd;
    logic [3:0]  t_be;
    int          t_age;
    logic        e_irv, e_drv, e_err;
    logic [31:0] e_ird, e_drd;
    logic        ip, dp, pick_d;

    assign ip     = i_req & ~e_irv;
    assign dp     = d_req & ~e_drv;
    assign pick_d = (ip && dp) ? ~last_g : dp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t_act <= 0; t_gr <= 0; t_port <= 0; t_we <= 0; t_addr <= 0; t_wd <= 0; t_be <= 0;
            t_age <= 0; last_g <= 0; e_irv <= 0; e_drv <= 0; e_err <= 0; e_ird <= 0; e_drd <= 0;
        end else begin
            e_irv <= 0;
            e_drv <= 0;
            if (!t_act) begin
                if (ip || dp) begin
                    t_act  <= 1;
                    t_gr   <= 0;
                    t_port <= pick_d;
                    t_addr <= pick_d ? d_addr : i_addr;
                    t_we   <= pick_d & d_we;
                    t_wd   <= d_wdata;
                    t_be   <= pick_d ? d_be : 4'hF;
                end
            end else if (!t_gr) begin
                if (mem_gnt) begin
                    t_gr   <= 1;
                    t_age  <= 0;
                    last_g <= t_port;
                end
            end else if (mem_rvalid || (TMO != 0 && t_age == TMO)) begin
                t_act <= 0;
                if (t_port) begin
                    e_drv <= 1;
                    e_drd <= mem_rvalid ? mem_rdata : 32'h0;
                end else begin
                    e_irv <= 1;
                    e_ird <= mem_rvalid ? mem_rdata : 32'h0;
                end
                if (!mem_rvalid) e_err <= 1;
            end else begin
                t_age <= t_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("i_rvalid", i_rvalid, e_irv);
            chk("d_rvalid", d_rvalid, e_drv);
            chk("i_rdata", i_rdata, e_ird);
            chk("d_rdata", d_rdata, e_drd);
            chk("i_stall", i_stall, i_req & ~e_irv);
            chk("d_stall", d_stall, d_req & ~e_drv);
            chk("bus_err", bus_err, e_err);
            chk("mem_req", mem_req, t_act & ~t_gr);
            if (t_act && !t_gr) begin
                chk("mem_addr", mem_addr, t_addr);
                chk("mem_we", mem_we, t_we);
                chk("mem_be", mem_be, t_be);
                if (t_we) chk("mem_wdata", mem_wdata, t_wd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: gd cycles of withheld grant, response rd cycles after grant (0 = never).
    task automatic serve(input int gd, input int rd, input logic [31:0] data, output int waited);
        waited = 0;
        while (!mem_req && waited < 20) begin
            tick();
            waited++;
        end
        chk("mem_req_seen", mem_req, 1);
        repeat (gd) tick();
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        if (rd > 0) begin
            repeat (rd - 1) tick();
            mem_rvalid = 1;
            mem_rdata  = data;
            tick();
            mem_rvalid = 0;
            mem_rdata  = 32'h5A5A_0000;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, c0, n;
        reset = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (2) tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_i_rvalid", i_rvalid, 0);
        chk("rst_d_rvalid", d_rvalid, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_mem_be", mem_be, 0);
        reset = 0;
        tick();

        // Contention right after reset: D wins, then I follows immediately.
        i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
        tick();
        chk("tie1_addr", mem_addr, 32'h80);
        serve(0, 1, 32'hD0D0_0001, w);
        chk("tie1_d_rvalid", d_rvalid, 1);
        chk("tie1_d_rdata", d_rdata, 32'hD0D0_0001);
        chk("tie1_i_rvalid", i_rvalid, 0);
        chk("tie1_i_stall", i_stall, 1);
        d_req = 0;
        serve(0, 1, 32'h1111_0040, w);
        chk("i_after_d_wait", w, 1);
        chk("tie1_i_rdata", i_rdata, 32'h1111_0040);
        chk("model_pin_ird", e_ird, 32'h1111_0040);
        i_req = 0;
        tick();
        i_req = 1; i_addr = 32'h44; d_req = 1; d_addr = 32'h84;
        tick();
        chk("tie2_addr", mem_addr, 32'h84);
        serve(0, 1, 32'hD0D0_0002, w);
        chk("tie2_d_rvalid", d_rvalid, 1);
        d_req = 0;
        serve(0, 1, 32'h1111_0044, w);
        chk("tie2_i_rdata", i_rdata, 32'h1111_0044);
        chk("tie2_d_hold", d_rdata, 32'hD0D0_0002);
        i_req = 0;
        tick();

        // Single load.
        d_req = 1; d_we = 0; d_addr = 32'h100;
        c0 = cyc;
        serve(0, 2, 32'hCAFE_BABE, w);
        chk("load_d_rvalid", d_rvalid, 1);
        chk("load_d_rdata", d_rdata, 32'hCAFE_BABE);
        chk("load_d_stall", d_stall, 0);
        chk("load_latency", cyc - c0, 4);
        chk("model_pin_drd", e_drd, 32'hCAFE_BABE);
        d_req = 0;
        tick();
        chk("load_one_pulse", d_rvalid, 0);

        // Store under grant backpressure.
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h1122_3344; d_be = 4'b0011;
        tick();
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_be", mem_be, 4'b0011);
        chk("st_mem_wdata", mem_wdata, 32'h1122_3344);
        serve(3, 1, 32'h0, w);
        chk("st_d_rvalid", d_rvalid, 1);
        d_req = 0; d_we = 0; d_be = 0; d_wdata = 0;
        tick();

        // Fetch timeout.
        i_req = 1; i_addr = 32'h300;
        serve(0, 0, 32'h0, w);
        n = 0;
        while (!i_rvalid && n < 20) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, 5);
        chk("tmo_i_rvalid", i_rvalid, 1);
        chk("tmo_i_rdata", i_rdata, 32'h0);
        chk("tmo_bus_err", bus_err, 1);
        i_req = 0;
        tick();
        mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_rvalid = 0;
        chk("late_i_rvalid", i_rvalid, 0);
        chk("late_bus_err", bus_err, 1);
        tick();

        // Back-to-back fetches with req held.
        i_req = 1; i_addr = 32'h0;
        serve(0, 1, 32'hA000_0000, w);
        chk("b2b1_i_rdata", i_rdata, 32'hA000_0000);
        chk("b2b1_i_stall", i_stall, 0);
        c0 = cyc;
        i_addr = 32'h4;
        serve(0, 1, 32'hA000_0004, w);
        chk("b2b2_i_rvalid", i_rvalid, 1);
        chk("b2b2_i_rdata", i_rdata, 32'hA000_0004);
        chk("b2b_gap", cyc - c0, 4);
        i_req = 0;
        tick();

        // Async reset while waiting for the response.
        d_req = 1; d_we = 0; d_addr = 32'h500;
        serve(0, 0, 32'h0, w);
        chk("pre_rst_d_stall", d_stall, 1);
        #2 reset = 1;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_d_rvalid", d_rvalid, 0);
        chk("arst_bus_err", bus_err, 0);
        chk("arst_d_stall", d_stall, 0);
        chk("arst_i_stall", i_stall, 0);
        d_req = 0;
        #10 reset = 0;
        tick();
        i_req = 1; i_addr = 32'h600;
        serve(0, 1, 32'h600D_F00D, w);
        chk("post_rst_i_rvalid", i_rvalid, 1);
        chk("post_rst_i_rdata", i_rdata, 32'h600D_F00D);
        chk("post_rst_bus_err", bus_err, 0);
        i_req = 0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
